// File: rtl/adders_pkg.sv
// Shared definitions for the adders datapath: FSM state encoding and index-width helper.
package adders_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    StIdle = ST_IDLE,
    StRun  = ST_RUN,
    StDone = ST_DONE
  } state_e;

  // Width of a counter that indexes `nibbles` slices; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice with carry-in and carry-out.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  assign g = a & b;
  assign p = a | b;

  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = a ^ b ^ c;

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder: one shared 4-bit lookahead slice walks the operands LSB nibble
// first, with the inter-nibble carry held in a register. Valid/ready on both sides.
module nibble_serial_adder
  import adders_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH:0]   sum,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / 4;
  localparam int unsigned IW      = idx_width(NIBBLES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, b_q;
  logic             carry_q, carry_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic [WIDTH:0]   sum_q, sum_d;
  logic             out_valid_q;
  logic             busy_q;
  logic             load;

  logic [3:0] nib_a, nib_b, nib_sum;
  logic       nib_cout;

  // Select the operand nibbles addressed by idx for the single shared slice.
  always_comb begin
    nib_a = '0;
    nib_b = '0;
    for (int n = 0; n < int'(NIBBLES); n++) begin
      if (idx_q == IW'(n)) begin
        nib_a = a_q[4*n +: 4];
        nib_b = b_q[4*n +: 4];
      end
    end
  end

  cla4_slice u_slice (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry_q),
    .sum  (nib_sum),
    .cout (nib_cout)
  );

  always_comb begin
    state_d = state_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    load    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          load    = 1'b1;
          carry_d = cin;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        for (int n = 0; n < int'(NIBBLES); n++) begin
          if (idx_q == IW'(n)) begin
            sum_d[4*n +: 4] = nib_sum;
          end
        end
        carry_d = nib_cout;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          sum_d[WIDTH] = nib_cout;
          idx_d        = '0;
          state_d      = StDone;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      carry_q     <= 1'b0;
      idx_q       <= '0;
      sum_q       <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      carry_q     <= carry_d;
      idx_q       <= idx_d;
      sum_q       <= sum_d;
      out_valid_q <= (state_d == StDone);
      busy_q      <= (state_d != StIdle);
      if (load) begin
        a_q <= a;
        b_q <= b;
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder at WIDTH=16, 8 and 4 against a cycle-timed arithmetic model.
module tb_nibble_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [15:0] a_s[3];
  logic [15:0] b_s[3];
  logic        cin_s[3];
  logic        iv_s[3];
  logic        or_s[3];

  logic        ir16, ov16, bz16;
  logic [16:0] s16;
  logic        ir8, ov8, bz8;
  logic [8:0]  s8;
  logic        ir4, ov4, bz4;
  logic [4:0]  s4;

  logic        ir_w[3];
  logic        ov_w[3];
  logic        bz_w[3];
  logic [16:0] sum_w[3];

  always_comb begin
    ir_w[0] = ir16; ov_w[0] = ov16; bz_w[0] = bz16; sum_w[0] = s16;
    ir_w[1] = ir8;  ov_w[1] = ov8;  bz_w[1] = bz8;  sum_w[1] = {8'b0, s8};
    ir_w[2] = ir4;  ov_w[2] = ov4;  bz_w[2] = bz4;  sum_w[2] = {12'b0, s4};
  end

  nibble_serial_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s[0]), .in_ready(ir16), .a(a_s[0]), .b(b_s[0]),
    .cin(cin_s[0]), .out_valid(ov16), .out_ready(or_s[0]), .sum(s16), .busy(bz16)
  );
  nibble_serial_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s[1]), .in_ready(ir8), .a(a_s[1][7:0]),
    .b(b_s[1][7:0]), .cin(cin_s[1]), .out_valid(ov8), .out_ready(or_s[1]), .sum(s8), .busy(bz8)
  );
  nibble_serial_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv_s[2]), .in_ready(ir4), .a(a_s[2][3:0]),
    .b(b_s[2][3:0]), .cin(cin_s[2]), .out_valid(ov4), .out_ready(or_s[2]), .sum(s4), .busy(bz4)
  );

  function automatic int nib_of(input int k);
    return (k == 0) ? 4 : (k == 1) ? 2 : 1;
  endfunction

  function automatic logic [15:0] mask_of(input int k);
    return (k == 0) ? 16'hFFFF : (k == 1) ? 16'h00FF : 16'h000F;
  endfunction

  int checks   = 0;
  int failures = 0;
  bit started  = 1'b0;

  task automatic check(input int k, input string name, input logic [16:0] act,
                       input logic [16:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL w%0d %s: got %h expected %h at %0t", 16 >> k, name, act, exp, $time);
    end
  endtask

  // Model: result = a+b+cin, visible NIBBLES edges after acceptance, held until taken.
  int          cyc = 0;
  int          due[3];
  bit          pend[3];
  bit          mval[3];
  bit          sknown[3];
  logic [16:0] msum[3];
  logic [16:0] mexp[3];

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        pend[k]   <= 1'b0;
        mval[k]   <= 1'b0;
        msum[k]   <= '0;
        sknown[k] <= 1'b1;
      end else if (mval[k]) begin
        if (or_s[k]) begin
          mval[k] <= 1'b0;
          pend[k] <= 1'b0;
        end
      end else if (!pend[k]) begin
        if (iv_s[k]) begin
          pend[k]   <= 1'b1;
          due[k]    <= cyc + nib_of(k);
          mexp[k]   <= 17'(a_s[k] & mask_of(k)) + 17'(b_s[k] & mask_of(k)) + 17'(cin_s[k]);
          sknown[k] <= 1'b0;
        end
      end else if (cyc == due[k]) begin
        mval[k]   <= 1'b1;
        msum[k]   <= mexp[k];
        sknown[k] <= 1'b1;
      end
    end
    cyc <= cyc + 1;
  end

  int last_acc[3];
  bit have_acc[3];

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 3; k++) begin
        check(k, "in_ready", 17'(ir_w[k]), 17'(!pend[k]));
        check(k, "out_valid", 17'(ov_w[k]), 17'(mval[k]));
        check(k, "busy", 17'(bz_w[k]), 17'(pend[k]));
        if (sknown[k]) check(k, "sum", sum_w[k], msum[k]);
        if (!rst_n) begin
          have_acc[k] = 1'b0;
        end else if (iv_s[k] && ir_w[k]) begin
          if (have_acc[k]) check(k, "ii_min", 17'(cyc - last_acc[k] >= nib_of(k) + 2), 17'd1);
          last_acc[k] = cyc;
          have_acc[k] = 1'b1;
        end
      end
    end
  end

  // All tasks are entered #1 after a rising edge.
  task automatic send(input int k, input logic [15:0] av, input logic [15:0] bv, input logic c);
    int n = 0;
    a_s[k]   = av;
    b_s[k]   = bv;
    cin_s[k] = c;
    iv_s[k]  = 1'b1;
    while (!ir_w[k] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) check(k, "accept_timeout", 17'd0, 17'd1);
    @(posedge clk); #1;
    iv_s[k] = 1'b0;
  endtask

  task automatic wait_valid(input int k, output int lat);
    lat = 0;
    while (!ov_w[k] && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic rand_ops(input int k, input int count);
    for (int i = 0; i < count; i++) begin
      bit hs = 1'b0;
      int n  = 0;
      send(k, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      while (!hs && n < 100) begin
        or_s[k] = 1'($urandom_range(0, 1));
        // Junk operands while still running must be ignored.
        iv_s[k] = !ov_w[k] && ($urandom_range(0, 3) == 0);
        if (iv_s[k]) a_s[k] = 16'($urandom);
        hs = ov_w[k] && or_s[k];
        @(posedge clk); #1;
        n++;
      end
      iv_s[k] = 1'b0;
      if (!hs) check(k, "handshake_timeout", 17'd0, 17'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      a_s[k] = '0; b_s[k] = '0; cin_s[k] = 1'b0; iv_s[k] = 1'b0; or_s[k] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
    started = 1'b1;
    check(0, "rst_in_ready", 17'(ir_w[0]), 17'd1);
    check(0, "rst_out_valid", 17'(ov_w[0]), 17'd0);
    check(0, "rst_busy", 17'(bz_w[0]), 17'd0);
    check(0, "rst_sum", sum_w[0], 17'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full carry ripple across all nibbles.
    send(0, 16'hFFFF, 16'h0001, 1'b0);
    wait_valid(0, lat);
    check(0, "lat_ffff", 17'(lat), 17'd4);
    check(0, "sum_ffff_1", sum_w[0], 17'h10000);
    @(posedge clk); #1;

    // Operands change during RUN; result must use the latched values.
    send(0, 16'h1234, 16'h4321, 1'b1);
    lat = 0;
    while (!ov_w[0] && lat < 50) begin
      a_s[0] = 16'($urandom); b_s[0] = 16'($urandom); cin_s[0] = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      lat++;
    end
    check(0, "lat_1234", 17'(lat), 17'd4);
    check(0, "sum_1234_4321_c", sum_w[0], 17'h05556);
    @(posedge clk); #1;

    // Backpressure: DONE and sum hold, new in_valid ignored.
    or_s[0] = 1'b0;
    send(0, 16'hFFFF, 16'hFFFF, 1'b0);
    wait_valid(0, lat);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        iv_s[0] = 1'b1; a_s[0] = 16'h1111; b_s[0] = 16'h2222;
      end
      check(0, "hold_valid", 17'(ov_w[0]), 17'd1);
      check(0, "hold_sum", sum_w[0], 17'h1FFFE);
      check(0, "hold_in_ready", 17'(ir_w[0]), 17'd0);
      @(posedge clk); #1;
    end
    iv_s[0] = 1'b0;
    or_s[0] = 1'b1;
    @(posedge clk); #1;
    check(0, "post_hs_ready", 17'(ir_w[0]), 17'd1);
    check(0, "post_hs_sum", sum_w[0], 17'h1FFFE);

    // Reset in the 2nd RUN cycle; reset also beats a simultaneous in_valid on the 4-bit unit.
    send(0, 16'h0102, 16'h0304, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    iv_s[2] = 1'b1; a_s[2] = 16'h0003; b_s[2] = 16'h0004;
    @(posedge clk); #1;
    check(0, "midrst_in_ready", 17'(ir_w[0]), 17'd1);
    check(0, "midrst_out_valid", 17'(ov_w[0]), 17'd0);
    check(0, "midrst_busy", 17'(bz_w[0]), 17'd0);
    check(0, "midrst_sum", sum_w[0], 17'd0);
    rst_n = 1'b1;
    iv_s[2] = 1'b0;
    @(posedge clk); #1;
    check(2, "rst_vs_valid_busy", 17'(bz_w[2]), 17'd0);
    send(0, 16'h00FF, 16'h0001, 1'b0);
    wait_valid(0, lat);
    check(0, "sum_00ff_1", sum_w[0], 17'h00100);
    @(posedge clk); #1;

    // Degenerate single-nibble unit.
    send(2, 16'h000F, 16'h000F, 1'b1);
    wait_valid(2, lat);
    check(2, "lat_w4", 17'(lat), 17'd1);
    check(2, "sum_w4", sum_w[2], 17'h0001F);
    @(posedge clk); #1;

    fork
      rand_ops(0, 25);
      rand_ops(1, 25);
    join
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
# nibble_serial_adder

Multi-cycle WIDTH-bit adder that sequences one 4-bit carry-lookahead slice over the operands a nibble per cycle, least significant nibble first. The carry is registered between nibbles. It trades latency for area wherever a wide add is rare, such as address or counter updates in the adders datapath. Operands enter through a valid/ready handshake and results leave through a second valid/ready handshake.

## Interface
Parameters:
- WIDTH, 16: operand width in bits. Must be a multiple of 4 and at least 4. NIBBLES = WIDTH/4.

Ports:
- clk  in  1  sole clock, rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  operands a, b, cin are presented
- in_ready  out  1  block can accept operands
- a  in  WIDTH  addend
- b  in  WIDTH  addend
- cin  in  1  carry into nibble 0
- out_valid  out  1  sum is valid
- out_ready  in  1  consumer accepts sum
- sum  out  WIDTH+1  result; sum[WIDTH] is the final carry-out
- busy  out  1  high in RUN or DONE

## Operation
- One clock. Reset is synchronous and active-low.
- States:
  - IDLE: in_ready=1. On in_valid, latch a, b and cin, clear idx, and go to RUN.
  - RUN: each cycle, add nibble idx of a and b plus the carry register through the slice. Write the 4-bit result into sum[4*idx+3:4*idx], store the slice carry-out, and increment idx. When idx==NIBBLES-1, write sum[WIDTH]=slice carry-out and go to DONE.
  - DONE: out_valid=1. On out_ready, go to IDLE.
- in_ready is exactly (state==IDLE). in_valid in RUN or DONE is ignored, not queued.
- sum, out_valid and busy are registered. sum holds its value in DONE until the handshake completes. After return to IDLE, sum keeps its last value until the next result overwrites it.
- Arithmetic: unsigned. sum = a + b + cin, exact in WIDTH+1 bits, no overflow flag.
- Per-nibble carry: c_out = g3 | p3&g2 | p3&p2&g1 | p3&p2&p1&g0 | p3&p2&p1&p0&c_in, with g=a&b and p=a|b.
- WIDTH=4 degenerates to a single RUN cycle.
- The latched operands are immune to changes on a, b or cin after acceptance.

## Timing
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, carry reg=0, idx=0.
- Accept at edge E0 (IDLE with in_valid). RUN occupies cycles E0+1 .. E0+NIBBLES. out_valid is high after edge E0+NIBBLES.
- Latency from accept to out_valid is NIBBLES cycles (4 at WIDTH=16).
- With out_ready held high, DONE lasts 1 cycle. The next accept is possible 1 cycle later, giving a minimum initiation interval of NIBBLES+2 cycles.
- out_ready low holds DONE and sum indefinitely. out_ready outside DONE has no effect.
- rst_n low in any state returns all registers to reset values on that edge. An in-flight operation is discarded and no partial sum is presented.
- rst_n low and in_valid high on the same edge: reset wins and nothing is accepted.

## Structure
- Shared package adders_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - the function computing the idx width, clog2(NIBBLES), minimum 1
- Sub-module cla4_slice is a combinational 4-bit lookahead slice with carry-in and carry-out (a[3:0], b[3:0], cin, sum[3:0], cout). It is instantiated once and muxed by idx.
- The top level contains only the FSM, operand registers, idx counter, carry register and sum register.

## Test plan
- WIDTH=16, a=16'hFFFF, b=16'h0001, cin=0, out_ready=1. Required: out_valid 4 cycles after accept and sum=17'h10000.
- a=16'h1234, b=16'h4321, cin=1. Required: sum=17'h05556. Toggling a/b/cin during RUN does not change the result.
- out_ready held low for 10 cycles in DONE. Required: out_valid and sum=17'h1FFFE (a=b=16'hFFFF) are stable, in_ready=0, and a new in_valid is ignored.
- rst_n asserted in the 2nd RUN cycle. Required: on the next cycle, in_ready=1, out_valid=0, busy=0 and sum=0. A subsequent add of 16'h00FF+16'h0001 yields 17'h00100.
- WIDTH=4, a=4'hF, b=4'hF, cin=1. Required: 1-cycle latency and sum=5'h1F.
- Back-to-back random ops with out_ready random, at WIDTH=16 and WIDTH=8. Every sum matches a+b+cin, and the initiation interval is never below NIBBLES+2.
